imem_fetch_ctrl: RTL and testbench

Fetch sequencer and port arbiter for the instruction memory. It owns the program counter and drives the IMEM address port during execution. It shares the same port with an external program loader while the core is idle or halted, and hands instructions to decode through a registered valid/ready stage. Jump and branch redirects from downstream reach the PC through this block.

---
 rtl/imem_fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// ---------------------------------------------------------------------------
// Fetch sequencer and instruction-memory port arbiter. It owns the program
// counter and, while the core is running, drives the IMEM address port from
// it. While idle or halted, the same port belongs to an external program
// loader. Fetched words go to decode through one registered valid/ready stage.
// Jump and branch redirects from downstream load the PC here and flush that
// stage.
//
// Ports
//   clk, reset              clock and synchronous active-high reset
//   start                   IDLE->RUN (PC=RESET_PC), HALTED->RUN (PC kept)
//   halt_req                RUN->HALTED, stops fetching
//   redirect, redirect_pc   load PC and flush the output stage
//   ld_valid/addr/data      loader write request
//   ld_ready                loader may write (IDLE or HALTED)
//   imem_addr/rdata         IMEM byte address and combinational read data
//   imem_we/wdata           IMEM write strobe and write data
//   if_valid/ready          output stage handshake towards decode
//   if_instr, if_pc         fetched instruction and its byte address
//   state                   IDLE=00 RUN=01 HALTED=10 FAULT=11
//   fault                   sticky fault flag, cleared only by reset
//   fetch_count             number of accepted transfers, wrapping
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        imem_we,
  output logic [31:0] imem_wdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [1:0]  state,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10,
    ST_FAULT  = 2'b11
  } state_e;

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        if_valid_q, if_valid_d;
  logic        fault_q, fault_d;

  logic        loader_owns_port;
  logic        ld_legal;
  logic        pc_legal;
  logic        xfer;
  logic        stage_free;

  // The loader owns the port in IDLE and HALTED; RUN and FAULT present the PC.
  assign loader_owns_port = (state_q == ST_IDLE) || (state_q == ST_HALTED);
  // Gating with reset keeps the memory from being written while reset is held.
  assign ld_ready   = loader_owns_port & ~reset;
  assign ld_legal   = (ld_addr[1:0] == 2'b00) && ({2'b00, ld_addr[31:2]} < DEPTH_W);
  assign imem_we    = ld_valid & ld_ready & ld_legal;
  assign imem_wdata = ld_data;
  assign imem_addr  = loader_owns_port ? ld_addr : pc_q;

  assign pc_legal   = (pc_q[1:0] == 2'b00) && ({2'b00, pc_q[31:2]} < DEPTH_W);
  assign xfer       = if_valid_q & if_ready;
  // The stage can take a new word if it is empty or is handing its word over now.
  assign stage_free = ~if_valid_q | if_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    fault_d       = fault_q;
    // An accepted entry leaves the stage unless something refills it below.
    if_valid_d    = if_valid_q & ~if_ready;
    fetch_count_d = fetch_count_q + {31'd0, xfer};

    if (state_q != ST_FAULT) begin
      if (redirect) begin
        // No fetch on a redirect edge; the target is checked when fetched.
        pc_d       = redirect_pc;
        if_valid_d = 1'b0;
        if (halt_req && (state_q == ST_RUN)) begin
          state_d = ST_HALTED;
        end
      end else if (halt_req && (state_q == ST_RUN)) begin
        state_d = ST_HALTED;
      end else if (start && (state_q == ST_IDLE)) begin
        state_d = ST_RUN;
        pc_d    = RESET_PC;
      end else if (start && (state_q == ST_HALTED)) begin
        state_d = ST_RUN;
      end else if ((state_q == ST_RUN) && stage_free) begin
        if (pc_legal) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
        end else begin
          // PC is kept so the faulting address stays visible on imem_addr.
          state_d    = ST_FAULT;
          fault_d    = 1'b1;
          if_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 32'd0;
      if_pc_q       <= 32'd0;
      fault_q       <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign state       = state_q;
  assign fault       = fault_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl
// Bench for imem_fetch_ctrl. The bench owns a behavioural IMEM, a reference
// model of the fetch controller and a scoreboard of expected transfers. The
// stimulus process advances the model once per clock and queues every word
// the model expects to enter the output stage; a separate monitor pops and
// compares at each observed if_valid & if_ready handshake.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 4096;
  localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2, S_FAULT = 3;

  logic        clk = 1'b0;
  logic        reset, start, halt_req, redirect;
  logic [31:0] redirect_pc;
  logic        ld_valid;
  logic [31:0] ld_addr, ld_data;
  logic        ld_ready;
  logic [31:0] imem_addr, imem_rdata, imem_wdata;
  logic        imem_we;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [1:0]  state;
  logic        fault;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.RESET_PC(RESET_PC), .IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_we(imem_we), .imem_wdata(imem_wdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .state(state), .fault(fault), .fetch_count(fetch_count)
  );

  // Unwritten IMEM words read as a fixed scramble of their index.
  function automatic logic [31:0] fill(input logic [31:0] idx);
    return (idx * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  // Behavioural IMEM: combinational read, write on the rising edge.
  logic [31:0] mem     [0:DEPTH-1];
  bit          mem_ok  [0:DEPTH-1];
  always @(posedge clk) begin
    if (imem_we) begin
      mem[imem_addr[13:2]]    <= imem_wdata;
      mem_ok[imem_addr[13:2]] <= 1'b1;
    end
  end
  assign imem_rdata = (imem_addr[31:2] < 30'(DEPTH)) ?
                      (mem_ok[imem_addr[13:2]] ? mem[imem_addr[13:2]] : fill({2'b00, imem_addr[31:2]}))
                      : 32'd0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model state
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } xfer_t;
  xfer_t       exp_q[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  int          m_state;
  logic [31:0] m_pc, m_ifpc, m_instr, m_count;
  bit          m_valid;

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < DEPTH);
  endfunction

  function automatic bit exp_we();
    return !reset && ld_valid && (m_state == S_IDLE || m_state == S_HALT) && legal(ld_addr);
  endfunction

  function automatic void drop_stage();
    if (m_valid) void'(exp_q.pop_back());
    m_valid = 0;
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  function automatic void model_step();
    bit accepted;
    if (reset) begin
      m_state = S_IDLE; m_pc = RESET_PC; m_valid = 0;
      m_ifpc = 0; m_instr = 0; m_count = 0;
      exp_q.delete();
      return;
    end
    if (exp_we()) ref_mem[ld_addr[13:2]] = ld_data;
    accepted = m_valid && if_ready;
    if (accepted) m_count = m_count + 1;
    m_valid = m_valid && !accepted;
    if (m_state == S_FAULT) return;
    if (redirect) begin
      drop_stage();
      m_pc = redirect_pc;
      if (halt_req && m_state == S_RUN) m_state = S_HALT;
    end else if (halt_req && m_state == S_RUN) begin
      m_state = S_HALT;
    end else if (start && m_state == S_IDLE) begin
      m_state = S_RUN;
      m_pc = RESET_PC;
    end else if (start && m_state == S_HALT) begin
      m_state = S_RUN;
    end else if (m_state == S_RUN && !m_valid) begin
      if (legal(m_pc)) begin
        m_valid = 1;
        m_ifpc  = m_pc;
        m_instr = ref_mem[m_pc[13:2]];
        exp_q.push_back({m_pc, m_instr});
        m_pc = m_pc + 4;
      end else begin
        drop_stage();
        m_state = S_FAULT;
      end
    end
  endfunction

  function automatic void check_outputs();
    check("state", {30'd0, state}, 32'(m_state));
    check("fault", {31'd0, fault}, {31'd0, m_state == S_FAULT});
    check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    check("if_pc", if_pc, m_ifpc);
    check("if_instr", if_instr, m_instr);
    check("fetch_count", fetch_count, m_count);
    check("ld_ready", {31'd0, ld_ready},
          {31'd0, !reset && (m_state == S_IDLE || m_state == S_HALT)});
  endfunction

  // Monitor: every handshake must match the oldest expected transfer.
  xfer_t mon_e;
  always @(negedge clk) begin
    if (if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL xfer_unexpected: got pc=%h required no transfer", if_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("xfer_pc", if_pc, mon_e.pc);
        check("xfer_instr", if_instr, mon_e.instr);
        $display("xfer pc=%h instr=%h", if_pc, if_instr);
      end
    end
  end

  // One clock of stimulus: drive, check the combinational port, step the model
  // at mid-cycle, then check registered outputs after the edge.
  task automatic cycle(input logic r, input logic st, input logic h, input logic rd,
                       input logic [31:0] rpc, input logic lv, input logic [31:0] la,
                       input logic [31:0] ld, input logic rdy);
    reset = r; start = st; halt_req = h; redirect = rd; redirect_pc = rpc;
    ld_valid = lv; ld_addr = la; ld_data = ld; if_ready = rdy;
    #1;
    check("imem_we", {31'd0, imem_we}, {31'd0, exp_we()});
    check("imem_addr", imem_addr, (m_state == S_RUN || m_state == S_FAULT) ? m_pc : la);
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'd0, 0, 32'd0, 32'd0, rdy);
  endtask

  task automatic rst1();
    cycle(1, 0, 0, 0, 32'd0, 0, 32'd0, 32'd0, 1);
  endtask

  task automatic go();
    cycle(0, 1, 0, 0, 32'd0, 0, 32'd0, 32'd0, 1);
  endtask

  task automatic jump(input logic [31:0] t, input logic h);
    cycle(0, 0, h, 1, t, 0, 32'd0, 32'd0, 1);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    cycle(0, 0, 0, 0, 32'd0, 1, a, d, 1);
  endtask

  initial begin
    reset = 1; start = 0; halt_req = 0; redirect = 0; redirect_pc = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0; if_ready = 1;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = fill(32'(i));
    m_state = S_IDLE; m_pc = RESET_PC; m_valid = 0; m_ifpc = 0; m_instr = 0; m_count = 0;
    @(posedge clk);
    #1;
    rst1(); rst1();

    // Load then run
    load(32'h0, 32'h2801_000F);
    load(32'h4, 32'h2802_0014);
    load(32'h8, 32'h0022_3020);
    go();
    idle(4, 1);
    // Backpressure, then release
    idle(3, 0);
    idle(2, 1);
    // Jump round trip
    jump(32'h1000, 0); idle(2, 1);
    jump(32'h0058, 0); idle(2, 1);
    // Halt, reload (one legal, one dropped), resume
    jump(32'h0010, 0); idle(2, 1);
    cycle(0, 0, 1, 0, 32'd0, 0, 32'd0, 32'd0, 0);
    load(32'h18, 32'hCAFE_0018);
    load(32'h4000, 32'hDEAD_4000);
    go(); idle(3, 1);
    // Redirect together with halt, then start at the redirect target
    jump(32'h0200, 1); idle(1, 1); go(); idle(3, 1);
    // Misaligned target faults; start is ignored until reset
    jump(32'h002A, 0); idle(3, 1); go(); idle(1, 1); rst1();
    // Sequential run off the end of IMEM
    go(); jump(32'h3FF0, 0); idle(8, 1); go(); rst1();
    // Reset in the middle of running
    go(); idle(3, 1); rst1(); idle(1, 1);

    // Randomized phase
    for (int n = 0; n < 4000; n++) begin
      logic r, st, h, rd, lv, rdy;
      logic [31:0] rpc, la;
      r   = (m_state == S_FAULT) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
      st  = ($urandom_range(0, 14) == 0);
      h   = ($urandom_range(0, 39) == 0);
      rd  = ($urandom_range(0, 19) == 0);
      if (rd) st = 0;
      lv  = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 4))
        0:       rpc = 32'h3FF0;
        1:       rpc = 32'h002A;
        2:       rpc = 32'h4000;
        3:       rpc = ($urandom_range(0, 4095) * 4) | 32'h2;
        default: rpc = $urandom_range(0, 4095) * 4;
      endcase
      case ($urandom_range(0, 3))
        0:       la = ($urandom_range(0, 4095) * 4) | 32'($urandom_range(1, 3));
        1:       la = 32'h4000 + $urandom_range(0, 255) * 4;
        default: la = $urandom_range(0, 4095) * 4;
      endcase
      cycle(r, st, h, rd, rpc, lv, la, $urandom, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
